cable_test_ctl: RTL and testbench

Test sequencer and scoreboard for the cable-test receive path. It holds the receiver in reset between runs and releases it for one run. It then pulses the packet generator, counts the packet-received and data-mismatch strobes from the receiver status bus, and enforces a no-progress watchdog. At the end it latches a result code and counters for the control/AXI-lite register block.

---
 rtl/cable_test_pkg.sv | 21 ++
 rtl/sat_counter.sv | 24 ++
 rtl/cable_test_ctl.sv | 158 +++++++++++++++
 tb/tb_cable_test_ctl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cable_test_pkg.sv
// rtl/cable_test_pkg.sv - shared types and defaults for the cable-test sequencer
package cable_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_PASS      = 2'd0,
    RES_FAIL_DATA = 2'd1,
    RES_TIMEOUT   = 2'd2,
    RES_ABORTED   = 2'd3
  } result_t;

  localparam int DEF_RX_RESET_CYCLES = 16;
  localparam int DEF_CW              = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - CW-bit up counter with clear, holding at all-ones
module sat_counter #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count
);

  // A clear with a simultaneous increment restarts the count at one, so the
  // clearing cycle itself is counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= CW'(inc);
    end else if (inc && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cable_test_ctl.sv
// rtl/cable_test_ctl.sv - run sequencer, packet/error scoreboard and watchdog
// for the cable-test receive path
module cable_test_ctl
  import cable_test_pkg::*;
#(
  parameter int RX_RESET_CYCLES = DEF_RX_RESET_CYCLES,
  parameter int CW              = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] packet_count,
  input  logic [CW-1:0] timeout_cycles,
  input  logic [1:0]    rx_status,
  output logic          rx_resetn,
  output logic          gen_start,
  output logic          busy,
  output logic          done,
  output logic [1:0]    result,
  output logic [CW-1:0] pkts_rcvd,
  output logic [CW-1:0] err_cycles,
  output logic [CW-1:0] first_err_pkt,
  output logic          err_seen
);

  state_t        state;
  logic [7:0]    prep_cnt;
  logic [CW-1:0] lat_count;
  logic [CW-1:0] lat_timeout;
  logic [CW-1:0] wd_count;

  logic pkt;
  logic err;
  logic in_run;
  logic start_ok;
  logic final_pkt;
  logic wd_fire;

  assign pkt       = rx_status[0];
  assign err       = rx_status[1];
  assign in_run    = (state == ST_RUN);
  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign final_pkt = in_run && pkt && ((pkts_rcvd + CW'(1)) == lat_count);
  // A packet in the same cycle restarts the watchdog, so it cannot also fire.
  assign wd_fire   = in_run && !pkt && (lat_timeout != '0) && (wd_count == lat_timeout);

  sat_counter #(.CW(CW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (in_run && err),
    .count (err_cycles)
  );

  sat_counter #(.CW(CW)) u_wd_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok || (in_run && pkt)),
    .inc   (in_run),
    .count (wd_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      prep_cnt      <= '0;
      lat_count     <= '0;
      lat_timeout   <= '0;
      pkts_rcvd     <= '0;
      first_err_pkt <= '0;
      err_seen      <= 1'b0;
      result        <= RES_PASS;
      rx_resetn     <= 1'b0;
      gen_start     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      gen_start <= 1'b0;

      if (in_run) begin
        if (pkt) begin
          pkts_rcvd <= pkts_rcvd + CW'(1);
        end
        if (err && !err_seen) begin
          err_seen      <= 1'b1;
          first_err_pkt <= pkts_rcvd;
        end
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_PREP;
            prep_cnt      <= 8'(RX_RESET_CYCLES - 1);
            lat_count     <= packet_count;
            lat_timeout   <= timeout_cycles;
            pkts_rcvd     <= '0;
            first_err_pkt <= '0;
            err_seen      <= 1'b0;
            result        <= RES_PASS;
            rx_resetn     <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end

        ST_PREP: begin
          if (abort) begin
            state     <= ST_DONE;
            result    <= RES_ABORTED;
            rx_resetn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (prep_cnt == 8'd0) begin
            if (lat_count == '0) begin
              state     <= ST_DONE;
              result    <= RES_PASS;
              rx_resetn <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state     <= ST_RUN;
              rx_resetn <= 1'b1;
              gen_start <= 1'b1;
            end
          end else begin
            prep_cnt <= prep_cnt - 8'd1;
          end
        end

        ST_RUN: begin
          if (abort || final_pkt || wd_fire) begin
            state     <= ST_DONE;
            rx_resetn <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            if (abort) begin
              result <= RES_ABORTED;
            end else if (final_pkt) begin
              result <= (err_seen || err) ? RES_FAIL_DATA : RES_PASS;
            end else begin
              result <= RES_TIMEOUT;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          rx_resetn <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cable_test_ctl.sv
// tb/tb_cable_test_ctl.sv - directed scoreboard bench for cable_test_ctl
module tb_cable_test_ctl;

  localparam int CW  = 32;
  localparam int RXC = 16;
  localparam int SCW = 8;

  localparam logic [1:0] R_PASS    = 2'd0;
  localparam logic [1:0] R_FAIL    = 2'd1;
  localparam logic [1:0] R_TIMEOUT = 2'd2;
  localparam logic [1:0] R_ABORTED = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, abort;
  logic [CW-1:0] packet_count, timeout_cycles;
  logic [1:0]    rx_status;
  logic          rx_resetn, gen_start, busy, done, err_seen;
  logic [1:0]    result;
  logic [CW-1:0] pkts_rcvd, err_cycles, first_err_pkt;

  logic           s_start, s_abort;
  logic [SCW-1:0] s_packet_count, s_timeout_cycles;
  logic [1:0]     s_rx_status;
  logic           s_rx_resetn, s_gen_start, s_busy, s_done, s_err_seen;
  logic [1:0]     s_result;
  logic [SCW-1:0] s_pkts_rcvd, s_err_cycles, s_first_err_pkt;

  cable_test_ctl #(.RX_RESET_CYCLES(RXC), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .packet_count(packet_count), .timeout_cycles(timeout_cycles),
    .rx_status(rx_status), .rx_resetn(rx_resetn), .gen_start(gen_start),
    .busy(busy), .done(done), .result(result), .pkts_rcvd(pkts_rcvd),
    .err_cycles(err_cycles), .first_err_pkt(first_err_pkt), .err_seen(err_seen)
  );

  cable_test_ctl #(.RX_RESET_CYCLES(1), .CW(SCW)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .packet_count(s_packet_count), .timeout_cycles(s_timeout_cycles),
    .rx_status(s_rx_status), .rx_resetn(s_rx_resetn), .gen_start(s_gen_start),
    .busy(s_busy), .done(s_done), .result(s_result), .pkts_rcvd(s_pkts_rcvd),
    .err_cycles(s_err_cycles), .first_err_pkt(s_first_err_pkt), .err_seen(s_err_seen)
  );

  typedef struct packed {
    logic [1:0]    res;
    logic [CW-1:0] pkts;
    logic [CW-1:0] errc;
    logic [CW-1:0] first;
    logic          seen;
  } exp_t;

  exp_t exp_q[$];
  int   n_asserts = 0;
  int   n_fail    = 0;
  int   gen_cnt   = 0;
  int   g0;
  int   n;

  always @(posedge clk) if (gen_start) gen_cnt <= gen_cnt + 1;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [CW-1:0] pc, input logic [CW-1:0] to, input exp_t e);
    packet_count   = pc;
    timeout_cycles = to;
    start          = 1'b1;
    exp_q.push_back(e);
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse(input logic [1:0] s);
    rx_status = s;
    cyc();
    rx_status = 2'b00;
  endtask

  task automatic wait_run(input int budget);
    int k = 0;
    while (!rx_resetn && k < budget) begin
      cyc();
      k++;
    end
    chk("run_entry", rx_resetn, 1);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_done"},   done, 1);
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_pkts"},   pkts_rcvd, e.pkts);
      chk({tag, "_errc"},   err_cycles, e.errc);
      chk({tag, "_first"},  first_err_pkt, e.first);
      chk({tag, "_seen"},   err_seen, e.seen);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rx_resetn"}, rx_resetn, 0);
    chk({tag, "_gen_start"}, gen_start, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_result"},    result, 0);
    chk({tag, "_pkts"},      pkts_rcvd, 0);
    chk({tag, "_errc"},      err_cycles, 0);
    chk({tag, "_first"},     first_err_pkt, 0);
    chk({tag, "_seen"},      err_seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish within time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; rx_status = 2'b00;
    packet_count = '0; timeout_cycles = '0;
    s_start = 1'b0; s_abort = 1'b0; s_rx_status = 2'b00;
    s_packet_count = '0; s_timeout_cycles = '0;
    repeat (3) cyc();
    check_idle("reset");
    reset = 1'b0;
    cyc();
    check_idle("idle");

    // clean run
    g0 = gen_cnt;
    start_run(4, 1000, '{res: R_PASS, pkts: 4, errc: 0, first: 0, seen: 1'b0});
    chk("clean_busy", busy, 1);
    chk("clean_rxr_low", rx_resetn, 0);
    n = 0;
    while (!rx_resetn && n < 100) begin
      n++;
      cyc();
    end
    chk("clean_prep_len", n, RXC);
    chk("clean_gen_start", gen_start, 1);
    pulse(2'b01);
    chk("clean_pkt1", pkts_rcvd, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      cyc();
      pulse(2'b01);
    end
    chk("clean_busy_off", busy, 0);
    chk("clean_rxr_off", rx_resetn, 0);
    check_result("clean");
    cyc();
    cyc();
    chk("clean_gen_once", gen_cnt - g0, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_in_done_done", done, 1);
    chk("abort_in_done_result", result, R_PASS);

    // data errors, also a restart from DONE
    start_run(3, 1000, '{res: R_FAIL, pkts: 3, errc: 3, first: 1, seen: 1'b1});
    chk("restart_pkts", pkts_rcvd, 0);
    chk("restart_done", done, 0);
    wait_run(40);
    pulse(2'b01);
    pulse(2'b10);
    chk("err_first_errc", err_cycles, 1);
    chk("err_first_pkt", first_err_pkt, 1);
    chk("err_first_seen", err_seen, 1);
    pulse(2'b10);
    cyc();
    pulse(2'b01);
    cyc();
    pulse(2'b11);
    check_result("data_err");

    // watchdog from the last packet
    start_run(5, 100, '{res: R_TIMEOUT, pkts: 2, errc: 0, first: 0, seen: 1'b0});
    chk("wd_restart_errc", err_cycles, 0);
    chk("wd_restart_seen", err_seen, 0);
    wait_run(40);
    pulse(2'b01);
    repeat (5) cyc();
    pulse(2'b01);
    repeat (99) cyc();
    chk("wd_not_early", done, 0);
    cyc();
    check_result("watchdog");

    // abort in PREP
    g0 = gen_cnt;
    start_run(2, 50, '{res: R_ABORTED, pkts: 0, errc: 0, first: 0, seen: 1'b0});
    repeat (5) cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_prep_busy", busy, 0);
    chk("abort_prep_rxr", rx_resetn, 0);
    check_result("abort_prep");
    repeat (20) cyc();
    chk("abort_prep_no_gen", gen_cnt - g0, 0);

    // abort mid-RUN, with an ignored start while running
    start_run(6, 0, '{res: R_ABORTED, pkts: 1, errc: 0, first: 0, seen: 1'b0});
    wait_run(40);
    pulse(2'b01);
    packet_count = 2;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_in_run_busy", busy, 1);
    chk("start_in_run_rxr", rx_resetn, 1);
    chk("start_in_run_pkts", pkts_rcvd, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_run_rxr", rx_resetn, 0);
    chk("abort_run_busy", busy, 0);
    check_result("abort_run");

    // zero packet count
    g0 = gen_cnt;
    start_run(0, 10, '{res: R_PASS, pkts: 0, errc: 0, first: 0, seen: 1'b0});
    n = 0;
    while (!done && n < 100) begin
      n++;
      cyc();
    end
    chk("zero_latency", n, RXC);
    check_result("zero");
    cyc();
    chk("zero_no_gen", gen_cnt - g0, 0);

    // timeout disabled
    start_run(5, 0, '{res: R_ABORTED, pkts: 0, errc: 0, first: 0, seen: 1'b0});
    wait_run(40);
    repeat (10000) cyc();
    chk("wd_off_busy", busy, 1);
    chk("wd_off_done", done, 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check_result("wd_off");

    // reset mid-RUN overrides every other input
    start_run(5, 0, '{res: R_PASS, pkts: 0, errc: 0, first: 0, seen: 1'b0});
    wait_run(40);
    pulse(2'b01);
    pulse(2'b10);
    chk("pre_reset_pkts", pkts_rcvd, 1);
    reset = 1'b1; start = 1'b1; abort = 1'b1; rx_status = 2'b11;
    cyc();
    check_idle("reset_mid");
    reset = 1'b0; start = 1'b0; abort = 1'b0; rx_status = 2'b00;
    void'(exp_q.pop_front());
    cyc();
    check_idle("after_reset");

    // 8-bit instance: one-cycle receiver reset and error counter saturation
    s_packet_count = 10;
    s_timeout_cycles = 0;
    s_start = 1'b1;
    cyc();
    s_start = 1'b0;
    chk("sat_prep_rxr", s_rx_resetn, 0);
    chk("sat_prep_busy", s_busy, 1);
    cyc();
    chk("sat_run_rxr", s_rx_resetn, 1);
    chk("sat_run_gen", s_gen_start, 1);
    s_rx_status = 2'b10;
    repeat (300) cyc();
    s_rx_status = 2'b00;
    chk("sat_errc", s_err_cycles, 255);
    chk("sat_seen", s_err_seen, 1);
    chk("sat_first", s_first_err_pkt, 0);
    s_abort = 1'b1;
    cyc();
    s_abort = 1'b0;
    chk("sat_done", s_done, 1);
    chk("sat_result", s_result, R_ABORTED);
    chk("sat_errc_hold", s_err_cycles, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
